// File: rtl/dsp_mac_pkg.sv
// Shared types and OPMODE encodings for the DSP48A1 multiply/accumulate sequencer.
package dsp_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CLR,
    DONE
  } mac_state_e;

  // X=M, Z=0 starts a fresh sum; X=M, Z=P accumulates onto it.
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;
  localparam logic [7:0] OPM_IDLE = 8'h00;

endpackage

// File: rtl/mac_tok_pipe.sv
// Shift register of {valid, first} tokens that shadows the slice's A/B and M
// register stages, so the controller knows when a product reaches P.
module mac_tok_pipe #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic tok_valid_i,
  input  logic tok_first_i,
  output logic tok_valid_o,
  output logic tok_first_o,
  output logic pending_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST;
      assign tok_valid_o    = tok_valid_i;
      assign tok_first_o    = tok_first_i;
      assign pending_o      = 1'b0;
    end else begin : g_regs
      logic [DEPTH-1:0] valid_q;
      logic [DEPTH-1:0] first_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_q <= '0;
          first_q <= '0;
        end else begin
          valid_q[0] <= tok_valid_i;
          first_q[0] <= tok_first_i;
          for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            first_q[i] <= first_q[i-1];
          end
        end
      end

      assign tok_valid_o = valid_q[DEPTH-1];
      assign tok_first_o = first_q[DEPTH-1];

      // Tokens still behind the output stage; the output stage itself drains this cycle.
      if (DEPTH > 1) begin : g_pend
        assign pending_o = |valid_q[DEPTH-2:0];
      end else begin : g_nopend
        assign pending_o = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_seq.sv
// Sequencer for one DSP48A1-style MAC slice: pulls operand pairs, drives the
// slice clock enables and OPMODE, and pulses done once P holds the dot product.
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int AB_REG = 1,
  parameter int M_REG  = 1,
  parameter int LEN_W  = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             done
);

  localparam int LAT = AB_REG + M_REG;

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;

  logic accept;
  logic tok_valid;
  logic tok_first;
  logic tok_pending;

  assign accept = in_valid && (state_q == RUN);

  mac_tok_pipe #(
    .DEPTH(LAT)
  ) u_tok_pipe (
    .CLK        (CLK),
    .RST        (RST),
    .tok_valid_i(accept),
    .tok_first_i(first_q),
    .tok_valid_o(tok_valid),
    .tok_first_o(tok_first),
    .pending_o  (tok_pending)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d     = RUN;
            remaining_d = len;
            first_d     = 1'b1;
          end else begin
            state_d = CLR;
          end
        end
      end
      RUN: begin
        if (accept) begin
          first_d     = 1'b0;
          remaining_d = remaining_q - LEN_W'(1);
          // With no slice registers the final P update coincides with the
          // last accept, so there is nothing left to drain.
          if (remaining_q == LEN_W'(1)) begin
            state_d = (LAT == 0) ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!tok_pending) begin
          state_d = DONE;
        end
      end
      CLR:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == RUN);
  assign ce_ab    = accept;
  assign ce_m     = busy;
  assign ce_p     = tok_valid;
  assign rst_p    = (state_q == CLR);
  assign done     = (state_q == DONE);
  assign opmode   = !tok_valid ? OPM_IDLE : (tok_first ? OPM_LOAD : OPM_ACC);

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Scoreboard bench for dsp_mac_seq: a behavioural slice model turns the
// controls into P, and monitors check ce_p/opmode/done against queued vectors.
module tb_dsp_mac_seq;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        sel = 1'b0;
  logic [9:0]  lenS = '0;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;

  int cyc = 0;
  int testsRun = 0;
  int testsFailed = 0;
  int s;

  exp_t cepQ[$];
  exp_t doneQ[$];
  exp_t cepQ0[$];
  exp_t doneQ0[$];

  logic       busy, inReady, ceAb, ceM, ceP, rstP, done;
  logic [7:0] opmode;
  logic       busy0, inReady0, ceAb0, ceM0, ceP0, rstP0, done0;
  logic [7:0] opmode0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  dsp_mac_seq dut (
    .CLK(CLK), .RST(RST), .start(start & ~sel), .len(lenS), .busy(busy),
    .in_valid(valid & ~sel), .in_ready(inReady), .ce_ab(ceAb), .ce_m(ceM),
    .ce_p(ceP), .rst_p(rstP), .opmode(opmode), .done(done)
  );

  dsp_mac_seq #(.AB_REG(0), .M_REG(0), .LEN_W(10)) dut0 (
    .CLK(CLK), .RST(RST), .start(start & sel), .len(lenS), .busy(busy0),
    .in_valid(valid & sel), .in_ready(inReady0), .ce_ab(ceAb0), .ce_m(ceM0),
    .ce_p(ceP0), .rst_p(rstP0), .opmode(opmode0), .done(done0)
  );

  function automatic logic [31:0] sliceAlu(input logic [7:0] op, input logic [31:0] p,
                                           input logic [31:0] m);
    case (op)
      8'h01:   return m;
      8'h09:   return p + m;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Behavioural slices: registered A/B/M/P for the default build, M combinational for dut0.
  logic [31:0] aQ, bQ, mQ, pQ, pQ0;
  always @(posedge CLK) begin
    if (ceAb) begin
      aQ <= aIn;
      bQ <= bIn;
    end
    if (ceM) mQ <= aQ * bQ;
    if (rstP) pQ <= '0;
    else if (ceP) pQ <= sliceAlu(opmode, pQ, mQ);
    if (rstP0) pQ0 <= '0;
    else if (ceP0) pQ0 <= sliceAlu(opmode0, pQ0, aIn * bIn);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectCep(input bit useZero, input int c, input int op);
    exp_t e;
    e.cyc = c;
    e.val = op;
    if (useZero) cepQ0.push_back(e);
    else cepQ.push_back(e);
  endtask

  task automatic expectDone(input bit useZero, input int c, input int p);
    exp_t e;
    e.cyc = c;
    e.val = p;
    if (useZero) doneQ0.push_back(e);
    else doneQ.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (ceP) begin
      if (cepQ.size() == 0) checkOutput("unexpected ce_p", ceP, 0);
      else begin
        e = cepQ.pop_front();
        checkOutput("ce_p cycle", cyc, e.cyc);
        checkOutput("opmode", opmode, e.val);
      end
    end
    if (done) begin
      if (doneQ.size() == 0) checkOutput("unexpected done", done, 0);
      else begin
        e = doneQ.pop_front();
        checkOutput("done cycle", cyc, e.cyc);
        checkOutput("P at done", pQ, e.val);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (ceP0) begin
      if (cepQ0.size() == 0) checkOutput("lat0 unexpected ce_p", ceP0, 0);
      else begin
        e = cepQ0.pop_front();
        checkOutput("lat0 ce_p cycle", cyc, e.cyc);
        checkOutput("lat0 opmode", opmode0, e.val);
      end
    end
    if (done0) begin
      if (doneQ0.size() == 0) checkOutput("lat0 unexpected done", done0, 0);
      else begin
        e = doneQ0.pop_front();
        checkOutput("lat0 done cycle", cyc, e.cyc);
        checkOutput("lat0 P at done", pQ0, e.val);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " in_ready"}, inReady, 0);
    checkOutput({tag, " ce_ab"}, ceAb, 0);
    checkOutput({tag, " ce_m"}, ceM, 0);
    checkOutput({tag, " ce_p"}, ceP, 0);
    checkOutput({tag, " rst_p"}, rstP, 0);
    checkOutput({tag, " opmode"}, opmode, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && (doneQ.size() + doneQ0.size()) > 0; i++) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("done outstanding", doneQ.size() + doneQ0.size(), 0);
    checkOutput("ce_p outstanding", cepQ.size() + cepQ0.size(), 0);
    doneQ.delete();
    doneQ0.delete();
    cepQ.delete();
    cepQ0.delete();
    @(posedge CLK);
    #1;
  endtask

  // Issues start, then offers pairs until n are accepted; optional stall and stray start.
  task automatic applyStimulus(input bit useZero, input int n, input int av[4], input int bv[4],
                               input int stallAfter, input int stallLen, input int pokeAt);
    int  idx = 0;
    int  stalled = 0;
    int  rel = 1;
    bit  acc;
    sel   = useZero;
    start = 1'b1;
    lenS  = n[9:0];
    valid = 1'b0;
    @(posedge CLK);
    #1;
    start = 1'b0;
    while (idx < n && rel < 200) begin
      if (rel == pokeAt) begin
        start = 1'b1;
        lenS  = 10'(n + 5);
      end else begin
        start = 1'b0;
      end
      if (idx == stallAfter && stalled < stallLen) begin
        valid = 1'b0;
        stalled++;
      end else begin
        valid = 1'b1;
        aIn   = av[idx];
        bIn   = bv[idx];
      end
      @(negedge CLK);
      acc = valid && (useZero ? inReady0 : inReady);
      @(posedge CLK);
      #1;
      if (acc) idx++;
      rel++;
    end
    valid = 1'b0;
    start = 1'b0;
    checkOutput("accept count", idx, n);
    @(negedge CLK);
    checkOutput("in_ready after last", useZero ? inReady0 : inReady, 0);
    @(posedge CLK);
    #1;
    waitDrain();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge CLK);
    checkResetState("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // len=4, 1..4 times 2, continuous valid
    s = cyc;
    expectCep(0, s + 3, 8'h01);
    expectCep(0, s + 4, 8'h09);
    expectCep(0, s + 5, 8'h09);
    expectCep(0, s + 6, 8'h09);
    expectDone(0, s + 7, 20);
    applyStimulus(0, 4, '{1, 2, 3, 4}, '{2, 2, 2, 2}, -1, 0, -1);

    // same vectors with a three-cycle gap after the second pair
    s = cyc;
    expectCep(0, s + 3, 8'h01);
    expectCep(0, s + 4, 8'h09);
    expectCep(0, s + 8, 8'h09);
    expectCep(0, s + 9, 8'h09);
    expectDone(0, s + 10, 20);
    applyStimulus(0, 4, '{1, 2, 3, 4}, '{2, 2, 2, 2}, 2, 3, -1);

    // len=0 clears P without touching the operand stream
    sel = 1'b0;
    s = cyc;
    expectDone(0, s + 2, 0);
    start = 1'b1;
    lenS  = '0;
    @(negedge CLK);
    checkOutput("len0 in_ready s", inReady, 0);
    checkOutput("len0 rst_p s", rstP, 0);
    @(posedge CLK);
    #1;
    start = 1'b0;
    @(negedge CLK);
    checkOutput("len0 rst_p s+1", rstP, 1);
    checkOutput("len0 in_ready s+1", inReady, 0);
    @(negedge CLK);
    checkOutput("len0 rst_p s+2", rstP, 0);
    checkOutput("len0 in_ready s+2", inReady, 0);
    @(posedge CLK);
    #1;
    waitDrain();

    // no slice registers: 5*7 lands in the accept cycle
    s = cyc;
    expectCep(1, s + 1, 8'h01);
    expectDone(1, s + 2, 35);
    applyStimulus(1, 1, '{5, 0, 0, 0}, '{7, 0, 0, 0}, -1, 0, -1);

    // reset after two of four accepts; the aborted run must not produce ce_p or done
    sel   = 1'b0;
    start = 1'b1;
    lenS  = 10'd4;
    aIn   = 1;
    bIn   = 2;
    @(posedge CLK);
    #1;
    start = 1'b0;
    valid = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    valid = 1'b0;
    RST   = 1'b1;
    #1;
    checkResetState("mid-run reset");
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    s = cyc;
    expectCep(0, s + 3, 8'h01);
    expectCep(0, s + 4, 8'h09);
    expectDone(0, s + 5, 25);
    applyStimulus(0, 2, '{3, 4, 0, 0}, '{3, 4, 0, 0}, -1, 0, -1);

    // stray start with a different len during RUN is ignored
    s = cyc;
    expectCep(0, s + 3, 8'h01);
    expectCep(0, s + 4, 8'h09);
    expectCep(0, s + 5, 8'h09);
    expectDone(0, s + 6, 30);
    applyStimulus(0, 3, '{1, 2, 3, 0}, '{5, 5, 5, 0}, -1, 0, 2);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
# dsp_mac_seq

Sequencer that drives one DSP48A1-style multiply/accumulate slice through an N-term dot product. It accepts a start command with a term count, pulls operand pairs from an upstream valid/ready stream, and generates the slice's clock-enable and OPMODE controls. It tracks operand tokens through the slice's A/B and M register stages and pulses done once P holds the finished sum. It sits between the operand buffer and the slice, and the slice is configured with OPMODEREG=0 and PREG=1.

## Interface
Parameters:
- AB_REG, 1, A/B input register stages in the slice (0 or 1).
- M_REG, 1, multiplier output register in the slice (0 or 1).
- LEN_W, 10, width of the term count.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- len  in  LEN_W  number of products to accumulate; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  upstream operand pair valid (data goes directly to the slice A/B pins).
- in_ready  out  1  controller accepts a pair this cycle.
- ce_ab  out  1  slice CEA/CEB.
- ce_m  out  1  slice CEM.
- ce_p  out  1  slice CEP.
- rst_p  out  1  slice RSTP (synchronous clear of P).
- opmode  out  8  slice OPMODE.
- done  out  1  one-cycle pulse; P is final during this cycle.

## Operation
- States: IDLE, RUN, DRAIN, CLR, DONE.
- IDLE:
  - start with len≠0 goes to RUN, loads remaining=len, sets first=1.
  - start with len=0 goes to CLR.
- RUN:
  - in_ready=1. An accept is in_valid&in_ready. ce_ab=accept.
  - Each accept pushes a token tagged with first into the token pipe, clears first, and decrements remaining.
  - The accept that takes remaining to 0 moves the FSM to DRAIN.
- DRAIN: in_ready=0. The FSM waits until the token pipe is empty and the last P update has occurred, then goes to DONE.
- CLR: rst_p=1 for one cycle, then DONE. Result is P=0.
- DONE: done=1 for one cycle, then IDLE.
- Token pipe:
  - Depth LAT=AB_REG+M_REG. It shifts every cycle and inserts a bubble when there is no accept.
  - With LAT=0 the pipe is a combinational pass-through of the accept.
- ce_m: 1 while busy, 0 in IDLE. Bubbles recompute stale products, which P ignores.
- ce_p: 1 only in a cycle where a token reaches the pipe output.
- opmode during a ce_p cycle:
  - Token with first=1: OPM_LOAD=8'h01 (X=M, Z=0).
  - Otherwise: OPM_ACC=8'h09 (X=M, Z=P).
- opmode is 8'h00 in all other cycles.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- RST at any time:
  - FSM returns to IDLE and the token pipe and remaining are cleared.
  - A sequence interrupted by reset produces no done. P content is undefined until the next sequence.
- Reset values: busy=0, in_ready=0, ce_ab=0, ce_m=0, ce_p=0, rst_p=0, opmode=8'h00, done=0.

## Timing
- An accept in cycle c gives ce_p in cycle c+LAT. The slice's P register updates at the end of that cycle.
- The last accept in cycle c gives done in cycle c+LAT+1.
  - Defaults: last accept at c, done at c+3.
- in_ready rises in the cycle after start is sampled. in_ready falls in the cycle after the final accept.
- start with len=0 gives rst_p in cycle s+1 and done in cycle s+2, where s is the start cycle.
- No back-to-back commands. A start coincident with done is ignored, so the earliest new start is one cycle after done.
- An upstream stall of k cycles delays done by exactly k cycles. Gaps never corrupt the sum.

## Structure
- Package dsp_mac_pkg holds:
  - the state enum;
  - OPM_LOAD=8'h01, OPM_ACC=8'h09, OPM_IDLE=8'h00.
- Sub-module mac_tok_pipe is a parameterised-depth shift register of {valid, first} with async reset and a DEPTH=0 bypass.

## Test plan
- Defaults, len=4, A=1,2,3,4, B=2, continuous valid:
  - accepts in cycles 1–4; ce_p in cycles 3–6;
  - opmode 01,09,09,09;
  - done in cycle 7 with P=20.
- Same stimulus with in_valid low for 3 cycles after the 2nd pair: done 3 cycles later, P=20, no extra ce_p.
- len=0: rst_p one cycle, done the next cycle, P=0, in_ready never high.
- AB_REG=0, M_REG=0, len=1, A=5, B=7: ce_p in the accept cycle, done the next cycle, P=35.
- RST asserted after 2 of 4 accepts: all outputs at reset values immediately. A fresh len=2 run (3×3, 4×4) gives P=25.
- start pulsed during RUN with a different len: ignored, so the original count and result are unaffected.
